bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one ram slave between NUM_CLIENTS client masters.
- All parties use the rq/ack/wr_ni/address/dataW/dataR bus protocol.
- Sits between the client instances and the ram. It muxes the granted client's request onto the ram port and routes ack and dataR back.
- A per-transaction timeout keeps a silent slave from locking the bus.

---
 rtl/bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing one ram slave between several
// rq/ack client masters. The granted client's request is muxed onto the
// ram port, and ack/dataR are routed back. A per-transaction timeout stops
// a silent slave from holding the bus forever.
module bus_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int NUM_CLIENTS = 4,
  parameter int GRANT_WIDTH = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            cl_rq,
  input  logic [NUM_CLIENTS-1:0]            cl_wr_ni,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_address,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_dataW,
  output logic [NUM_CLIENTS-1:0]            cl_ack,
  output logic [NUM_CLIENTS-1:0]            cl_err,
  output logic [DATA_WIDTH-1:0]             cl_dataR,
  output logic                              mem_rq,
  output logic                              mem_wr_ni,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [DATA_WIDTH-1:0]             mem_dataW,
  input  logic                              mem_ack,
  input  logic [DATA_WIDTH-1:0]             mem_dataR,
  output logic [GRANT_WIDTH-1:0]            grant_id,
  output logic                              busy
);

  // The counter only ever needs to reach TIMEOUT-1 before BUSY is left.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [GRANT_WIDTH-1:0] LAST_ID  = GRANT_WIDTH'(NUM_CLIENTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [GRANT_WIDTH-1:0] r_grant_id;
  logic [GRANT_WIDTH-1:0] w_grant_next;
  logic [GRANT_WIDTH-1:0] r_rr_ptr;
  logic [GRANT_WIDTH-1:0] w_rr_next;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_next;

  logic                   w_pick_valid;
  logic [GRANT_WIDTH-1:0] w_pick_id;
  logic [NUM_CLIENTS-1:0] w_grant_onehot;

  logic                   w_wr_ni [NUM_CLIENTS];
  logic [ADDR_WIDTH-1:0]  w_addr  [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0]  w_dataw [NUM_CLIENTS];

  // Unpack the flat client buses into per-client views and build the
  // one-hot decode of the current grant.
  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      assign w_wr_ni[gi]        = cl_wr_ni[gi];
      assign w_addr[gi]         = cl_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_dataw[gi]        = cl_dataW[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_grant_onehot[gi] = (r_grant_id == GRANT_WIDTH'(gi));
    end
  endgenerate

  // The ram port always follows the grant; it only matters while mem_rq is high.
  assign mem_wr_ni   = w_wr_ni[r_grant_id];
  assign mem_address = w_addr[r_grant_id];
  assign mem_dataW   = w_dataw[r_grant_id];
  assign cl_dataR    = mem_dataR;
  assign grant_id    = r_grant_id;

  // Cyclic search for the first requesting client, starting at rr_ptr.
  always_comb begin
    logic [GRANT_WIDTH-1:0] idx;
    w_pick_valid = 1'b0;
    w_pick_id    = r_rr_ptr;
    idx          = r_rr_ptr;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (!w_pick_valid && cl_rq[idx]) begin
        w_pick_valid = 1'b1;
        w_pick_id    = idx;
      end
      idx = (idx == LAST_ID) ? '0 : idx + 1'b1;
    end
  end

  // State register, grant, round-robin pointer and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant_id <= w_grant_next;
      r_rr_ptr   <= w_rr_next;
      r_count    <= w_count_next;
    end
  end

  // Next-state logic and handshake outputs; ack beats timeout beats abandon.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant_id;
    w_rr_next    = r_rr_ptr;
    w_count_next = r_count;
    mem_rq       = 1'b0;
    busy         = 1'b0;
    cl_ack       = '0;
    cl_err       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant_next = w_pick_id;
          w_count_next = '0;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mem_rq       = 1'b1;
        busy         = 1'b1;
        w_count_next = r_count + 1'b1;
        if (mem_ack) begin
          cl_ack       = w_grant_onehot;
          w_state_next = ST_DONE;
        end else if (r_count == CNT_LAST) begin
          cl_err       = w_grant_onehot;
          w_state_next = ST_DONE;
        end else if (!cl_rq[r_grant_id]) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Rotate priority past the client just served.
        w_rr_next    = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed test of bus_arbiter with a combinational-ack ram model.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cl_rq;
  logic [3:0]  cl_wr_ni;
  logic [15:0] cl_address;
  logic [31:0] cl_dataW;
  logic [3:0]  cl_ack;
  logic [3:0]  cl_err;
  logic [7:0]  cl_dataR;
  logic        mem_rq;
  logic        mem_wr_ni;
  logic [3:0]  mem_address;
  logic [7:0]  mem_dataW;
  logic        mem_ack;
  logic [7:0]  mem_dataR;
  logic [1:0]  grant_id;
  logic        busy;

  logic        ram_en;
  logic [7:0]  ram [16];

  int checks = 0;
  int errors = 0;

  bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .cl_rq       (cl_rq),
    .cl_wr_ni    (cl_wr_ni),
    .cl_address  (cl_address),
    .cl_dataW    (cl_dataW),
    .cl_ack      (cl_ack),
    .cl_err      (cl_err),
    .cl_dataR    (cl_dataR),
    .mem_rq      (mem_rq),
    .mem_wr_ni   (mem_wr_ni),
    .mem_address (mem_address),
    .mem_dataW   (mem_dataW),
    .mem_ack     (mem_ack),
    .mem_dataR   (mem_dataR),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Ram model: single-cycle ack while enabled, asynchronous read.
  assign mem_ack   = mem_rq & ram_en;
  assign mem_dataR = ram[mem_address];

  // Ram contents: known pattern on reset, address 3 holds A5.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'(i * 17);
      ram[3] <= 8'hA5;
    end else if (mem_rq && mem_ack && mem_wr_ni) begin
      ram[mem_address] <= mem_dataW;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_client(input int i, input logic wr, input logic [3:0] a, input logic [7:0] d);
    cl_wr_ni[i]          = wr;
    cl_address[i*4 +: 4] = a;
    cl_dataW[i*8 +: 8]   = d;
  endtask

  initial begin
    reset      = 1'b1;
    cl_rq      = '0;
    cl_wr_ni   = '0;
    cl_address = '0;
    cl_dataW   = '0;
    ram_en     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    $display("reset: mem_rq=%0b busy=%0b grant_id=%0d", mem_rq, busy, grant_id);
    check("reset_mem_rq", 32'(mem_rq), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_grant", 32'(grant_id), 32'd0);
    check("reset_ack", 32'(cl_ack), 32'd0);
    check("reset_err", 32'(cl_err), 32'd0);

    // Single read by client 2 from address 3.
    set_client(2, 1'b0, 4'h3, 8'h00);
    cl_rq = 4'b0100;
    tick();
    $display("read c2: grant=%0d addr=%0h ack=%b dataR=%0h", grant_id, mem_address, cl_ack, cl_dataR);
    check("rd_mem_rq", 32'(mem_rq), 32'd1);
    check("rd_busy", 32'(busy), 32'd1);
    check("rd_addr", 32'(mem_address), 32'h3);
    check("rd_wr_ni", 32'(mem_wr_ni), 32'd0);
    check("rd_ack", 32'(cl_ack), 32'b0100);
    check("rd_dataR", 32'(cl_dataR), 32'hA5);
    check("rd_grant", 32'(grant_id), 32'd2);
    cl_rq = '0;
    tick();
    check("rd_done_mem_rq", 32'(mem_rq), 32'd0);
    check("rd_done_ack", 32'(cl_ack), 32'd0);
    tick();

    // All four request at once from reset: grants 0,1,2,3.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) set_client(c, 1'b0, 4'(c + 4), 8'h00);
    cl_rq = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      tick();
      $display("all4: grant=%0d ack=%b mem_rq=%0b", grant_id, cl_ack, mem_rq);
      check("all4_grant", 32'(grant_id), 32'(g));
      check("all4_ack", 32'(cl_ack), 32'(4'b0001 << g));
      check("all4_addr", 32'(mem_address), 32'(g + 4));
      cl_rq[g] = 1'b0;
      tick();
      check("all4_gap_mem_rq", 32'(mem_rq), 32'd0);
      tick();
    end

    // Fairness: client 0 holds rq, client 3 requests once.
    set_client(0, 1'b0, 4'h1, 8'h00);
    set_client(3, 1'b0, 4'h2, 8'h00);
    cl_rq = 4'b1001;
    tick();
    $display("fair 1: grant=%0d ack=%b", grant_id, cl_ack);
    check("fair1_grant", 32'(grant_id), 32'd0);
    check("fair1_ack", 32'(cl_ack), 32'b0001);
    tick();
    tick();
    tick();
    $display("fair 2: grant=%0d ack=%b", grant_id, cl_ack);
    check("fair2_grant", 32'(grant_id), 32'd3);
    check("fair2_ack", 32'(cl_ack), 32'b1000);
    cl_rq[3] = 1'b0;
    tick();
    tick();
    tick();
    $display("fair 3: grant=%0d ack=%b", grant_id, cl_ack);
    check("fair3_grant", 32'(grant_id), 32'd0);
    check("fair3_ack", 32'(cl_ack), 32'b0001);
    cl_rq = '0;
    tick();
    tick();

    // Write 5C to F from client 1, then read it back.
    set_client(1, 1'b1, 4'hF, 8'h5C);
    cl_rq = 4'b0010;
    tick();
    $display("write c1: wr_ni=%0b addr=%0h dataW=%0h ack=%b", mem_wr_ni, mem_address, mem_dataW, cl_ack);
    check("wr_wr_ni", 32'(mem_wr_ni), 32'd1);
    check("wr_addr", 32'(mem_address), 32'hF);
    check("wr_dataW", 32'(mem_dataW), 32'h5C);
    check("wr_ack", 32'(cl_ack), 32'b0010);
    cl_rq = '0;
    tick();
    tick();
    set_client(1, 1'b0, 4'hF, 8'h00);
    cl_rq = 4'b0010;
    tick();
    $display("read c1: wr_ni=%0b addr=%0h dataR=%0h ack=%b", mem_wr_ni, mem_address, cl_dataR, cl_ack);
    check("rb_wr_ni", 32'(mem_wr_ni), 32'd0);
    check("rb_dataR", 32'(cl_dataR), 32'h5C);
    check("rb_ack", 32'(cl_ack), 32'b0010);
    cl_rq = '0;
    tick();
    tick();

    // Timeout: ram silent, client 1 requests; pointer is at 2.
    ram_en = 1'b0;
    cl_rq  = 4'b0010;
    tick();
    check("to_grant", 32'(grant_id), 32'd1);
    for (int i = 0; i < 15; i++) begin
      check("to_wait_err", 32'(cl_err), 32'd0);
      check("to_wait_mem_rq", 32'(mem_rq), 32'd1);
      tick();
    end
    $display("timeout: err=%b ack=%b mem_rq=%0b", cl_err, cl_ack, mem_rq);
    check("to_err", 32'(cl_err), 32'b0010);
    check("to_ack", 32'(cl_ack), 32'd0);
    cl_rq = '0;
    tick();
    check("to_done_mem_rq", 32'(mem_rq), 32'd0);
    check("to_done_err", 32'(cl_err), 32'd0);
    tick();
    ram_en = 1'b1;
    cl_rq  = 4'b0110;
    tick();
    $display("after timeout: grant=%0d ack=%b", grant_id, cl_ack);
    check("to_next_grant", 32'(grant_id), 32'd2);
    check("to_next_ack", 32'(cl_ack), 32'b0100);
    cl_rq = '0;
    tick();
    tick();

    // Reset in the middle of a BUSY transaction.
    ram_en = 1'b0;
    cl_rq  = 4'b1000;
    tick();
    check("rst_busy_grant", 32'(grant_id), 32'd3);
    check("rst_busy_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("mid reset: mem_rq=%0b busy=%0b grant=%0d ack=%b err=%b", mem_rq, busy, grant_id, cl_ack, cl_err);
    check("rst_mid_mem_rq", 32'(mem_rq), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_grant", 32'(grant_id), 32'd0);
    check("rst_mid_ack", 32'(cl_ack), 32'd0);
    check("rst_mid_err", 32'(cl_err), 32'd0);

    // Abandon: granted client 3 drops rq while the ram is silent.
    tick();
    check("ab_grant", 32'(grant_id), 32'd3);
    check("ab_busy", 32'(busy), 32'd1);
    cl_rq = '0;
    #1;
    check("ab_busy_ack", 32'(cl_ack), 32'd0);
    check("ab_busy_err", 32'(cl_err), 32'd0);
    tick();
    $display("abandon: mem_rq=%0b busy=%0b ack=%b err=%b", mem_rq, busy, cl_ack, cl_err);
    check("ab_done_mem_rq", 32'(mem_rq), 32'd0);
    check("ab_done_busy", 32'(busy), 32'd0);
    check("ab_done_ack", 32'(cl_ack), 32'd0);
    check("ab_done_err", 32'(cl_err), 32'd0);
    tick();
    check("ab_idle_busy", 32'(busy), 32'd0);
    check("ab_idle_mem_rq", 32'(mem_rq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
